scsp_midi_tx: RTL and testbench



---
 rtl/scsp_pkg.sv | 6 +
 rtl/scsp_midi_fifo.sv | 47 ++++
 rtl/scsp_midi_tx.sv | 89 ++++++++
 tb/tb_scsp_midi_tx.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/scsp_pkg.sv
// scsp_pkg: shared SCSP types and constants for the MIDI transmit path
package scsp_pkg;
    localparam int MIDI_BAUD_DIV   = 722;
    localparam int MIDI_FIFO_DEPTH = 4;
    typedef enum logic [1:0] {MTX_IDLE, MTX_START, MTX_DATA, MTX_STOP} MidiTxState_t;
endpackage

// File: rtl/scsp_midi_fifo.sv
// scsp_midi_fifo: synchronous FIFO with clock enable and same-cycle read/write
// clk/rst/ce: clock, sync active-high reset, clock enable
// wr/din: push strobe and data; rd: pop strobe; dout: head entry
// empty/full: registered status flags
module scsp_midi_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         wr,
    input  logic         rd,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt, cnt_n;
    logic          we, re;
    assign re    = ce & rd & ~empty;
    // a pop in the same cycle frees the slot, so a write to a full FIFO is still taken
    assign we    = ce & wr & (~full | re);
    assign cnt_n = cnt + (AW+1)'(we) - (AW+1)'(re);
    assign dout  = mem[rp];
    always_ff @(posedge clk)
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else if (ce) begin
            if (we) begin
                mem[wp] <= din;
                wp      <= wp + 1'b1;
            end
            if (re) rp <= rp + 1'b1;
            cnt   <= cnt_n;
            empty <= cnt_n == '0;
            full  <= cnt_n == FULL_CNT;
        end
endmodule

// File: rtl/scsp_midi_tx.sv
// scsp_midi_tx: MOBUF FIFO plus 8N1 MIDI OUT serializer driving CR2 OE/OF
// CLK/RST/CE: system clock, sync active-high reset, clock enable
// MOBUF_WR/MOBUF_D: CR3 write strobe and byte
// OE/OF: FIFO empty/full; BUSY: frame in progress; TXD: serial line, idle high
module scsp_midi_tx
    import scsp_pkg::*;
#(
    parameter int BAUD_DIV   = MIDI_BAUD_DIV,
    parameter int FIFO_DEPTH = MIDI_FIFO_DEPTH
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CE,
    input  logic       MOBUF_WR,
    input  logic [7:0] MOBUF_D,
    output logic       OE,
    output logic       OF,
    output logic       BUSY,
    output logic       TXD
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(BAUD_DIV - 1);
    MidiTxState_t  state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bitcnt, bitcnt_n;
    logic [7:0]    shift, shift_n, head;
    logic          txd_n, pop, tick;
    scsp_midi_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk  (CLK),
        .rst  (RST),
        .ce   (CE),
        .wr   (MOBUF_WR),
        .rd   (pop),
        .din  (MOBUF_D),
        .dout (head),
        .empty(OE),
        .full (OF)
    );
    assign tick = cnt == '0;
    assign BUSY = state != MTX_IDLE;
    always_comb begin
        state_n  = state;
        cnt_n    = tick ? RELOAD : cnt - 1'b1;
        bitcnt_n = bitcnt;
        shift_n  = shift;
        pop      = 1'b0;
        unique case (state)
            MTX_IDLE: begin
                cnt_n = OE ? cnt : RELOAD;
                if (!OE) begin
                    pop     = 1'b1;
                    shift_n = head;
                    state_n = MTX_START;
                end
            end
            MTX_START: if (tick) begin
                bitcnt_n = '0;
                state_n  = MTX_DATA;
            end
            MTX_DATA: if (tick) begin
                shift_n  = shift >> 1;
                bitcnt_n = bitcnt + 1'b1;
                state_n  = bitcnt == 3'd7 ? MTX_STOP : MTX_DATA;
            end
            MTX_STOP: if (tick) begin
                // chain straight into the next start bit when more bytes are queued
                pop     = ~OE;
                shift_n = OE ? shift : head;
                state_n = OE ? MTX_IDLE : MTX_START;
            end
        endcase
        // line level is decided from the next state so TXD stays a plain register
        txd_n = state_n == MTX_START ? 1'b0 : state_n == MTX_DATA ? shift_n[0] : 1'b1;
    end
    always_ff @(posedge CLK)
        if (RST) begin
            state  <= MTX_IDLE;
            cnt    <= '0;
            bitcnt <= '0;
            shift  <= '0;
            TXD    <= 1'b1;
        end else if (CE) begin
            state  <= state_n;
            cnt    <= cnt_n;
            bitcnt <= bitcnt_n;
            shift  <= shift_n;
            TXD    <= txd_n;
        end
endmodule

// File: tb/tb_scsp_midi_tx.sv
// tb_scsp_midi_tx: table-driven check of the MIDI transmit FIFO and serializer
module tb_scsp_midi_tx;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       CE = 1'b1;
    logic       MOBUF_WR = 1'b0;
    logic [7:0] MOBUF_D = 8'h00;
    logic       OE, OF, BUSY, TXD;
    int vecs = 0;
    int bad = 0;
    typedef struct {
        logic       rst, ce, wr;
        logic [7:0] d;
        logic       txd, oe, of, busy;
    } vec_t;
    vec_t       tv[$];
    logic [7:0] txq[$];
    scsp_midi_tx #(.BAUD_DIV(4), .FIFO_DEPTH(4)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .CE      (CE),
        .MOBUF_WR(MOBUF_WR),
        .MOBUF_D (MOBUF_D),
        .OE      (OE),
        .OF      (OF),
        .BUSY    (BUSY),
        .TXD     (TXD)
    );
    always #5 CLK = ~CLK;
    task automatic check(input string name, input int cyc, input logic t, input logic o, input logic f, input logic b);
        vecs++;
        if ({TXD, OE, OF, BUSY} !== {t, o, f, b}) begin
            bad++;
            $display("FAIL %s cycle %0d: txd/oe/of/busy got %b%b%b%b want %b%b%b%b",
                     name, cyc, TXD, OE, OF, BUSY, t, o, f, b);
        end
    endtask
    function automatic logic line_at(int e);
        int f, k;
        if (e < 2) return 1'b1;
        f = (e - 2) / 40;
        k = ((e - 2) % 40) / 4;
        if (f >= txq.size()) return 1'b1;
        return k == 0 ? 1'b0 : k == 9 ? 1'b1 : txq[f][k-1];
    endfunction
    // frames start at effective cycle 2 and follow each other back to back
    task automatic build(input int n, input int p, input int oe_lo, input int oe_hi, input int of_lo, input int of_hi);
        tv.delete();
        for (int c = 0; c < n; c++) begin
            int   e = (c + p - 1) / p;
            vec_t v;
            v.rst  = 1'b0;
            v.ce   = (c % p) == 0;
            v.wr   = 1'b0;
            v.d    = 8'h00;
            v.txd  = line_at(e);
            v.oe   = !(e >= oe_lo && e <= oe_hi);
            v.of   = e >= of_lo && e <= of_hi;
            v.busy = e >= 2 && (e - 2) / 40 < txq.size();
            tv.push_back(v);
        end
    endtask
    task automatic wr_at(input int c, input logic [7:0] d);
        vec_t v;
        v = tv[c];
        v.wr = 1'b1;
        v.d = d;
        tv[c] = v;
    endtask
    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        CE = 1'b1;
        MOBUF_WR = 1'b0;
        @(negedge CLK);
        check("reset", 0, 1'b1, 1'b1, 1'b0, 1'b0);
        RST = 1'b0;
    endtask
    task automatic run(input string name);
        foreach (tv[i]) begin
            if (i != 0) @(negedge CLK);
            check(name, i, tv[i].txd, tv[i].oe, tv[i].of, tv[i].busy);
            RST = tv[i].rst;
            CE = tv[i].ce;
            MOBUF_WR = tv[i].wr;
            MOBUF_D = tv[i].d;
        end
        @(negedge CLK);
        MOBUF_WR = 1'b0;
        CE = 1'b1;
    endtask
    initial begin
        do_reset();
        txq = '{8'hA5};
        build(44, 1, 1, 1, 1, 0);
        wr_at(0, 8'hA5);
        run("single");
        do_reset();
        txq = '{8'h00, 8'hFF, 8'h55};
        build(125, 1, 1, 81, 1, 0);
        wr_at(0, 8'h00);
        wr_at(1, 8'hFF);
        wr_at(2, 8'h55);
        run("b2b");
        do_reset();
        txq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        build(205, 1, 1, 161, 5, 41);
        for (int i = 0; i < 6; i++) wr_at(i, 8'(i + 1));
        run("overflow");
        do_reset();
        txq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h77};
        build(245, 1, 1, 201, 5, 81);
        for (int i = 0; i < 5; i++) wr_at(i, 8'(i + 1));
        wr_at(41, 8'h77);
        run("fullpop");
        do_reset();
        txq = '{8'h3C};
        build(132, 3, 1, 1, 1, 0);
        wr_at(0, 8'h3C);
        run("cegate");
        do_reset();
        txq = '{8'h81, 8'h11, 8'h22};
        build(19, 1, 1, 500, 1, 0);
        wr_at(0, 8'h81);
        wr_at(1, 8'h11);
        wr_at(2, 8'h22);
        run("prerst");
        check("bit3", 19, 1'b0, 1'b0, 1'b0, 1'b1);
        RST = 1'b1;
        @(negedge CLK);
        check("abort", 20, 1'b1, 1'b1, 1'b0, 1'b0);
        RST = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge CLK);
            check("quiet", 21 + i, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
        $finish;
    end
endmodule
